pipe_ctrl_gen2: RTL and testbench

Parametrised successor to the fixed 3-stage instruction-control pipeline. It holds the decode (ID) and execute (EX) stage registers for opcode, operand, next-PC and flag. It adds a valid/ready fetch handshake, load-use stall insertion, flush on taken control transfer, and a downstream freeze. It sits between instruction fetch and the EX-stage control decoder, which consumes ex_opcode/ex_flag unchanged.

---
 rtl/pipe_ctrl_gen2.sv | 196 +++++++++++++++++++
 tb/tb_pipe_ctrl_gen2.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_gen2
// Brief    : ID/EX instruction-control pipeline with fetch handshake,
//            load-use stall, flush on taken transfer and downstream freeze.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_gen2 #(
    parameter int OPW  = 8,
    parameter int ORW  = 8,
    parameter int AW   = 8,
    parameter int RAW  = 3,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPW+ORW-1:0]   instr_in,
    input  logic                 instr_valid,
    input  logic [AW-1:0]        pc_in,
    input  logic                 flag_in,
    output logic                 fetch_ready,
    input  logic                 ex_hold,
    output logic [RAW-1:0]       read_address,
    output logic                 ex_valid,
    output logic [OPW-1:0]       ex_opcode,
    output logic [ORW-1:0]       ex_operand,
    output logic [AW-1:0]        ex_npc,
    output logic                 ex_flag,
    output logic [RAW-1:0]       write_address,
    output logic                 redirect,
    output logic [1:0]           redirect_kind,
    output logic [CNTW-1:0]      stall_count,
    output logic [CNTW-1:0]      flush_count
);

    localparam int         c_MAJ_W    = 5;
    localparam logic [1:0] c_KIND_NONE = 2'b00;
    localparam logic [1:0] c_KIND_DIR  = 2'b01;
    localparam logic [1:0] c_KIND_RET  = 2'b10;
    localparam logic [1:0] c_KIND_ABS  = 2'b11;

    logic                id_valid_q,   id_valid_d;
    logic [OPW-1:0]      id_opcode_q,  id_opcode_d;
    logic [ORW-1:0]      id_operand_q, id_operand_d;
    logic [AW-1:0]       id_npc_q,     id_npc_d;
    logic                id_flag_q,    id_flag_d;
    logic                ex_valid_q,   ex_valid_d;
    logic [OPW-1:0]      ex_opcode_q,  ex_opcode_d;
    logic [ORW-1:0]      ex_operand_q, ex_operand_d;
    logic [AW-1:0]       ex_npc_q,     ex_npc_d;
    logic                ex_flag_q,    ex_flag_d;
    logic [CNTW-1:0]     stall_count_q, stall_count_d;
    logic [CNTW-1:0]     flush_count_q, flush_count_d;

    logic [c_MAJ_W-1:0]  w_ex_major;
    logic [2:0]          w_ex_reg;
    logic [c_MAJ_W-1:0]  w_id_major;
    logic                w_uncond;
    logic                w_cond;
    logic [1:0]          w_kind;
    logic                w_ex_load;
    logic                w_stall;
    logic                w_accept;

    assign w_ex_major = ex_opcode_q[OPW-1 -: c_MAJ_W];
    assign w_ex_reg   = ex_opcode_q[2:0];
    assign w_id_major = id_opcode_q[OPW-1 -: c_MAJ_W];

    always_comb begin
        w_uncond = 1'b0;
        w_cond   = 1'b0;
        w_kind   = c_KIND_NONE;
        case (w_ex_major)
            5'b00000: begin
                case (w_ex_reg)
                    3'b011, 3'b101: begin w_uncond = 1'b1; w_kind = c_KIND_DIR; end
                    3'b100, 3'b110: begin w_uncond = 1'b1; w_kind = c_KIND_ABS; end
                    3'b111:         begin w_uncond = 1'b1; w_kind = c_KIND_RET; end
                    default:        ;
                endcase
            end
            5'b00001, 5'b00110: begin w_cond = 1'b1; w_kind = c_KIND_DIR; end
            5'b00101, 5'b00111: begin w_cond = 1'b1; w_kind = c_KIND_ABS; end
            5'b01001:           begin w_cond = 1'b1; w_kind = c_KIND_RET; end
            default:            ;
        endcase
    end

    assign w_ex_load = ((w_ex_major == 5'b01110) && (w_ex_reg != 3'b000)) ||
                       (w_ex_major == 5'b01111);

    assign read_address  = id_opcode_q[RAW-1:0];
    assign ex_valid      = ex_valid_q;
    assign ex_opcode     = ex_valid_q ? ex_opcode_q : '0;
    assign ex_operand    = ex_operand_q;
    assign ex_npc        = ex_npc_q;
    assign ex_flag       = ex_flag_q;
    assign write_address = ex_opcode[RAW-1:0];
    assign stall_count   = stall_count_q;
    assign flush_count   = flush_count_q;

    // Stall compares against the NOP-forced EX opcode, so a bubble never hazards.
    assign w_stall = ex_valid_q & w_ex_load & id_valid_q &
                     (w_id_major != 5'b00000) & (read_address == write_address);

    // Gated by rst_n so a pending transfer never escapes while reset is held.
    assign redirect      = rst_n & ex_valid_q & ~ex_hold & (w_uncond | (w_cond & ex_flag_q));
    assign redirect_kind = redirect ? w_kind : c_KIND_NONE;
    assign fetch_ready   = rst_n & ~ex_hold & ~w_stall & ~redirect;
    assign w_accept      = instr_valid & fetch_ready;

    always_comb begin
        id_valid_d    = id_valid_q;
        id_opcode_d   = id_opcode_q;
        id_operand_d  = id_operand_q;
        id_npc_d      = id_npc_q;
        id_flag_d     = id_flag_q;
        ex_valid_d    = ex_valid_q;
        ex_opcode_d   = ex_opcode_q;
        ex_operand_d  = ex_operand_q;
        ex_npc_d      = ex_npc_q;
        ex_flag_d     = ex_flag_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;

        if (ex_hold) begin
            // Frozen: everything holds, nothing counts.
        end else if (redirect) begin
            id_valid_d    = 1'b0;
            id_opcode_d   = '0;
            id_operand_d  = '0;
            id_npc_d      = '0;
            id_flag_d     = 1'b0;
            ex_valid_d    = 1'b0;
            ex_opcode_d   = '0;
            ex_operand_d  = '0;
            ex_npc_d      = '0;
            ex_flag_d     = 1'b0;
            if (flush_count_q != '1) begin
                flush_count_d = flush_count_q + 1'b1;
            end
        end else if (w_stall) begin
            ex_valid_d    = 1'b0;
            ex_opcode_d   = '0;
            ex_operand_d  = '0;
            ex_npc_d      = '0;
            ex_flag_d     = 1'b0;
            if (stall_count_q != '1) begin
                stall_count_d = stall_count_q + 1'b1;
            end
        end else begin
            id_valid_d    = w_accept;
            id_opcode_d   = w_accept ? instr_in[OPW+ORW-1:ORW] : '0;
            id_operand_d  = w_accept ? instr_in[ORW-1:0]       : '0;
            id_npc_d      = w_accept ? pc_in                   : '0;
            id_flag_d     = w_accept & flag_in;
            ex_valid_d    = id_valid_q;
            ex_opcode_d   = id_opcode_q;
            ex_operand_d  = id_operand_q;
            ex_npc_d      = id_npc_q;
            ex_flag_d     = id_flag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid_q    <= 1'b0;
            id_opcode_q   <= '0;
            id_operand_q  <= '0;
            id_npc_q      <= '0;
            id_flag_q     <= 1'b0;
            ex_valid_q    <= 1'b0;
            ex_opcode_q   <= '0;
            ex_operand_q  <= '0;
            ex_npc_q      <= '0;
            ex_flag_q     <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            id_valid_q    <= id_valid_d;
            id_opcode_q   <= id_opcode_d;
            id_operand_q  <= id_operand_d;
            id_npc_q      <= id_npc_d;
            id_flag_q     <= id_flag_d;
            ex_valid_q    <= ex_valid_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_operand_q  <= ex_operand_d;
            ex_npc_q      <= ex_npc_d;
            ex_flag_q     <= ex_flag_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl_gen2
// Brief    : Scoreboard bench for pipe_ctrl_gen2 (default and CNTW=2 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_gen2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic [7:0]  pc_in;
    logic        flag_in;
    logic        ex_hold;

    logic        fetch_ready, ex_valid, ex_flag, redirect;
    logic [2:0]  read_address, write_address;
    logic [7:0]  ex_opcode, ex_operand, ex_npc;
    logic [1:0]  redirect_kind;
    logic [7:0]  stall_count, flush_count;

    logic        fetch_ready2, ex_valid2, ex_flag2, redirect2;
    logic [2:0]  read_address2, write_address2;
    logic [7:0]  ex_opcode2, ex_operand2, ex_npc2;
    logic [1:0]  redirect_kind2;
    logic [1:0]  stall_count2, flush_count2;

    int          checks = 0;
    int          errors = 0;
    int          exp_stall, exp_flush, exp_stall2, exp_flush2;
    logic [24:0] sb[$];
    logic [24:0] mon_exp;
    logic        hold_prev = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl_gen2 u_dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .pc_in(pc_in), .flag_in(flag_in), .fetch_ready(fetch_ready), .ex_hold(ex_hold),
        .read_address(read_address), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_operand(ex_operand), .ex_npc(ex_npc), .ex_flag(ex_flag),
        .write_address(write_address), .redirect(redirect), .redirect_kind(redirect_kind),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_ctrl_gen2 #(.CNTW(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .pc_in(pc_in), .flag_in(flag_in), .fetch_ready(fetch_ready2), .ex_hold(ex_hold),
        .read_address(read_address2), .ex_valid(ex_valid2), .ex_opcode(ex_opcode2),
        .ex_operand(ex_operand2), .ex_npc(ex_npc2), .ex_flag(ex_flag2),
        .write_address(write_address2), .redirect(redirect2), .redirect_kind(redirect_kind2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    // Each instruction entering EX is popped once; frozen cycles repeat it.
    always @(posedge clk) hold_prev <= ex_hold;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ex_valid === 1'b1 && !hold_prev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got op=%h opr=%h npc=%h flag=%b expected none",
                         ex_opcode, ex_operand, ex_npc, ex_flag);
            end else begin
                mon_exp = sb.pop_front();
                if ({ex_opcode, ex_operand, ex_npc, ex_flag, ex_valid2,
                     ex_opcode2, ex_operand2, ex_npc2, ex_flag2, read_address2} !==
                    {mon_exp, 1'b1, mon_exp, read_address}) begin
                    errors++;
                    $display("FAIL sb_ex_stage got %h/%h/%h/%b dut2 %b %h/%h/%h/%b expected %h",
                             ex_opcode, ex_operand, ex_npc, ex_flag, ex_valid2,
                             ex_opcode2, ex_operand2, ex_npc2, ex_flag2, mon_exp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [7:0] pc, input logic f);
        instr_valid = 1'b1;
        instr_in    = ins;
        pc_in       = pc;
        flag_in     = f;
    endtask

    task automatic drive_idle();
        instr_valid = 1'b0;
        instr_in    = '0;
        pc_in       = '0;
        flag_in     = 1'b0;
    endtask

    task automatic model_clear();
        sb.delete();
        exp_stall = 0; exp_flush = 0; exp_stall2 = 0; exp_flush2 = 0;
    endtask

    task automatic model_flush();
        exp_flush  = (exp_flush  == 255) ? 255 : exp_flush + 1;
        exp_flush2 = (exp_flush2 == 3)   ? 3   : exp_flush2 + 1;
    endtask

    task automatic model_stall();
        exp_stall  = (exp_stall  == 255) ? 255 : exp_stall + 1;
        exp_stall2 = (exp_stall2 == 3)   ? 3   : exp_stall2 + 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_hold = 1'b0;
        drive_idle();
        model_clear();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({fetch_ready, ex_valid, ex_opcode, ex_operand, ex_npc, ex_flag, redirect,
             redirect_kind, read_address, write_address, stall_count, flush_count,
             stall_count2, flush_count2, fetch_ready2, redirect2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b op=%h cnt=%h/%h expected all zero",
                     fetch_ready, ex_valid, ex_opcode, stall_count, flush_count);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({fetch_ready, ex_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got rdy=%b v=%b expected 1 0", fetch_ready, ex_valid);
        end
        next_cycle();
    endtask

    // One instruction through an otherwise empty pipeline.
    task automatic run_single(input logic [15:0] ins, input logic [7:0] pc, input logic f,
                              input logic exp_r, input logic [1:0] exp_k);
        issue(ins, pc, f);
        sb.push_back({ins, pc, f});
        @(negedge clk);
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_accept ins=%h got rdy=%b expected 1", ins, fetch_ready);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if ({ex_valid, ex_opcode, read_address} !== {1'b0, 8'h00, ins[10:8]}) begin
            errors++;
            $display("FAIL single_id ins=%h got v=%b op=%h ra=%0d expected 0 00 %0d",
                     ins, ex_valid, ex_opcode, read_address, ins[10:8]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({redirect, redirect_kind, redirect2, redirect_kind2, write_address,
             write_address2, fetch_ready, fetch_ready2} !==
            {exp_r, exp_k, exp_r, exp_k, ins[10:8], ins[10:8], ~exp_r, ~exp_r}) begin
            errors++;
            $display("FAIL single_ex ins=%h f=%b got redir=%b kind=%b wa=%0d rdy=%b expected %b %b %0d %b",
                     ins, f, redirect, redirect_kind, write_address, fetch_ready,
                     exp_r, exp_k, ins[10:8], ~exp_r);
        end
        if (exp_r) model_flush();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ex_valid, flush_count, flush_count2} !== {1'b0, exp_flush[7:0], exp_flush2[1:0]}) begin
            errors++;
            $display("FAIL single_flush ins=%h got v=%b fc=%0d fc2=%0d expected 0 %0d %0d",
                     ins, ex_valid, flush_count, flush_count2, exp_flush, exp_flush2);
        end
        next_cycle();
    endtask

    // Producer/consumer pair back-to-back, then a third word presented during the stall.
    task automatic run_pair(input logic [15:0] i0, input logic [15:0] i1, input logic stall);
        issue(i0, 8'h20, 1'b0);
        sb.push_back({i0, 8'h20, 1'b0});
        next_cycle();
        issue(i1, 8'h21, 1'b0);
        sb.push_back({i1, 8'h21, 1'b0});
        @(negedge clk);
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL pair_second_accept i1=%h got rdy=%b expected 1", i1, fetch_ready);
        end
        next_cycle();
        issue(16'h9000, 8'h22, 1'b0);
        @(negedge clk);
        checks++;
        if ({fetch_ready, fetch_ready2, ex_opcode} !== {~stall, ~stall, i0[15:8]}) begin
            errors++;
            $display("FAIL pair_hazard i0=%h i1=%h got rdy=%b op=%h expected %b %h",
                     i0, i1, fetch_ready, ex_opcode, ~stall, i0[15:8]);
        end
        if (stall) begin
            model_stall();
            next_cycle();
            @(negedge clk);
            checks++;
            if ({ex_valid, ex_opcode, fetch_ready, stall_count, stall_count2} !==
                {1'b0, 8'h00, 1'b1, exp_stall[7:0], exp_stall2[1:0]}) begin
                errors++;
                $display("FAIL pair_bubble got v=%b op=%h rdy=%b sc=%0d sc2=%0d expected 0 00 1 %0d %0d",
                         ex_valid, ex_opcode, fetch_ready, stall_count, stall_count2,
                         exp_stall, exp_stall2);
            end
        end
        sb.push_back({16'h9000, 8'h22, 1'b0});
        next_cycle();
        drive_idle();
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if ({sb.size() == 0, stall_count, stall_count2} !== {1'b1, exp_stall[7:0], exp_stall2[1:0]}) begin
            errors++;
            $display("FAIL pair_drain got pending=%0d sc=%0d sc2=%0d expected 0 %0d %0d",
                     sb.size(), stall_count, stall_count2, exp_stall, exp_stall2);
        end
        next_cycle();
    endtask

    task automatic test_basic();
        run_single(16'h8A05, 8'h11, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_load_use();
        run_pair(16'h7301, 16'h8301, 1'b1);
        run_pair(16'h7001, 16'h8001, 1'b0);
        run_pair(16'h7201, 16'h0200, 1'b0);
        run_pair(16'h7F01, 16'h8701, 1'b1);
    endtask

    task automatic test_jump();
        issue(16'h0320, 8'h30, 1'b0);
        sb.push_back({16'h0320, 8'h30, 1'b0});
        next_cycle();
        issue(16'h4100, 8'h31, 1'b0);
        next_cycle();
        issue(16'h4200, 8'h32, 1'b0);
        @(negedge clk);
        checks++;
        if ({redirect, redirect_kind, fetch_ready, ex_opcode} !== {1'b1, 2'b01, 1'b0, 8'h03}) begin
            errors++;
            $display("FAIL jump_redirect got r=%b k=%b rdy=%b op=%h expected 1 01 0 03",
                     redirect, redirect_kind, fetch_ready, ex_opcode);
        end
        model_flush();
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if ({ex_valid, redirect, flush_count, flush_count2} !==
            {1'b0, 1'b0, exp_flush[7:0], exp_flush2[1:0]}) begin
            errors++;
            $display("FAIL jump_flush got v=%b r=%b fc=%0d expected 0 0 %0d",
                     ex_valid, redirect, flush_count, exp_flush);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_killed got v=%b op=%h expected 0", ex_valid, ex_opcode);
        end
        next_cycle();
    endtask

    task automatic test_transfer_classes();
        logic [19:0] tbl [13] = '{
            {16'h2910, 1'b0, 1'b0, 2'b00}, {16'h2910, 1'b1, 1'b1, 2'b11},
            {16'h4F00, 1'b1, 1'b1, 2'b10}, {16'h4F00, 1'b0, 1'b0, 2'b00},
            {16'h0400, 1'b0, 1'b1, 2'b11}, {16'h0500, 1'b0, 1'b1, 2'b01},
            {16'h0600, 1'b0, 1'b1, 2'b11}, {16'h0700, 1'b1, 1'b1, 2'b10},
            {16'h0200, 1'b1, 1'b0, 2'b00}, {16'h0800, 1'b1, 1'b1, 2'b01},
            {16'h3000, 1'b1, 1'b1, 2'b01}, {16'h3800, 1'b1, 1'b1, 2'b11},
            {16'h1000, 1'b1, 1'b0, 2'b00}
        };
        for (int i = 0; i < 13; i++) begin
            run_single(tbl[i][19:4], 8'(8'h70 + i), tbl[i][3], tbl[i][2], tbl[i][1:0]);
        end
    endtask

    task automatic test_hold();
        issue(16'h7301, 8'h40, 1'b0);
        sb.push_back({16'h7301, 8'h40, 1'b0});
        next_cycle();
        issue(16'h8301, 8'h41, 1'b0);
        sb.push_back({16'h8301, 8'h41, 1'b0});
        next_cycle();
        ex_hold = 1'b1;
        issue(16'h9000, 8'h42, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({fetch_ready, redirect, ex_valid, ex_opcode, read_address, stall_count, stall_count2} !==
                {1'b0, 1'b0, 1'b1, 8'h73, 3'd3, exp_stall[7:0], exp_stall2[1:0]}) begin
                errors++;
                $display("FAIL hold_freeze cyc=%0d got rdy=%b r=%b v=%b op=%h ra=%0d sc=%0d expected 0 0 1 73 3 %0d",
                         k, fetch_ready, redirect, ex_valid, ex_opcode, read_address, stall_count, exp_stall);
            end
            next_cycle();
        end
        ex_hold = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({fetch_ready, ex_opcode} !== {1'b0, 8'h73}) begin
            errors++;
            $display("FAIL hold_release_stall got rdy=%b op=%h expected 0 73", fetch_ready, ex_opcode);
        end
        model_stall();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ex_valid, stall_count, stall_count2} !== {1'b0, exp_stall[7:0], exp_stall2[1:0]}) begin
            errors++;
            $display("FAIL hold_bubble got v=%b sc=%0d sc2=%0d expected 0 %0d %0d",
                     ex_valid, stall_count, stall_count2, exp_stall, exp_stall2);
        end
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL hold_drain got pending=%0d expected 0", sb.size());
        end
        next_cycle();
        // Freeze with a taken jump sitting in EX.
        issue(16'h0320, 8'h50, 1'b0);
        sb.push_back({16'h0320, 8'h50, 1'b0});
        next_cycle();
        drive_idle();
        next_cycle();
        ex_hold = 1'b1;
        @(negedge clk);
        checks++;
        if ({redirect, redirect_kind, fetch_ready, ex_valid} !== {1'b0, 2'b00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hold_jump got r=%b k=%b rdy=%b v=%b expected 0 00 0 1",
                     redirect, redirect_kind, fetch_ready, ex_valid);
        end
        next_cycle();
        ex_hold = 1'b0;
        @(negedge clk);
        checks++;
        if ({redirect, redirect_kind, flush_count} !== {1'b1, 2'b01, exp_flush[7:0]}) begin
            errors++;
            $display("FAIL hold_jump_release got r=%b k=%b fc=%0d expected 1 01 %0d",
                     redirect, redirect_kind, flush_count, exp_flush);
        end
        model_flush();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({ex_valid, flush_count, flush_count2} !== {1'b0, exp_flush[7:0], exp_flush2[1:0]}) begin
            errors++;
            $display("FAIL hold_jump_flush got v=%b fc=%0d fc2=%0d expected 0 %0d %0d",
                     ex_valid, flush_count, flush_count2, exp_flush, exp_flush2);
        end
        next_cycle();
    endtask

    task automatic test_saturate();
        test_reset();
        for (int i = 0; i < 5; i++) begin
            run_single(16'h0500, 8'(8'h90 + i), 1'b0, 1'b1, 2'b01);
        end
        issue(16'h0320, 8'h60, 1'b0);
        sb.push_back({16'h0320, 8'h60, 1'b0});
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({redirect, flush_count2} !== {1'b1, 2'd3}) begin
            errors++;
            $display("FAIL sat_pre_reset got r=%b fc2=%0d expected 1 3", redirect, flush_count2);
        end
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({redirect, fetch_ready} !== 2'b00) begin
            errors++;
            $display("FAIL sat_in_reset got r=%b rdy=%b expected 0 0", redirect, fetch_ready);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ex_valid, flush_count, flush_count2, stall_count, stall_count2, fetch_ready} !==
            {1'b0, 8'd0, 2'd0, 8'd0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL sat_after_reset got v=%b fc=%0d fc2=%0d sc=%0d rdy=%b expected 0 0 0 0 1",
                     ex_valid, flush_count, flush_count2, stall_count, fetch_ready);
        end
        next_cycle();
    endtask

    task automatic test_reset_abort();
        issue(16'h7301, 8'h80, 1'b0);
        sb.push_back({16'h7301, 8'h80, 1'b0});
        next_cycle();
        issue(16'h8301, 8'h81, 1'b0);
        sb.push_back({16'h8301, 8'h81, 1'b0});
        next_cycle();
        drive_idle();
        @(negedge clk);
        checks++;
        if (fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_stall got rdy=%b expected 0", fetch_ready);
        end
        #1 rst_n = 1'b0;
        model_clear();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ex_valid, stall_count, stall_count2, fetch_ready} !== {1'b0, 8'd0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL abort_clean got v=%b sc=%0d sc2=%0d rdy=%b expected 0 0 0 1",
                     ex_valid, stall_count, stall_count2, fetch_ready);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_id_cleared got v=%b op=%h expected 0", ex_valid, ex_opcode);
        end
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        ex_hold = 1'b0;
        drive_idle();
        model_clear();
        test_reset();
        test_basic();
        test_load_use();
        test_jump();
        test_transfer_classes();
        test_hold();
        test_saturate();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
